// File: rtl/amstrad_pkg.sv
// Shared constants and types for the Amstrad ROM download path.
package amstrad_pkg;

  // SDRAM ROM pages ({rom_space, page[7:0]}) used by the loader
  localparam logic [8:0] PAGE_OS          = 9'h000;  // lower (OS) ROM
  localparam logic [8:0] PAGE_BASIC       = 9'h100;  // upper ROM 0
  localparam logic [8:0] PAGE_AMSDOS      = 9'h107;  // upper ROM 7
  localparam logic [8:0] PAGE_HIGH        = 9'h1FF;  // last upper ROM slot
  localparam logic [8:0] PAGE_EXP_DEFAULT = 9'h1EE;  // expansion ROM without a page hint

  // Byte transfer sequencer states
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WRITE
  } load_state_t;

  // Decode one ASCII hex digit ('0'-'9', 'A'-'F'); result is {valid, value}
  function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) begin
      return {1'b1, ch[3:0]};
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      return {1'b1, ch[3:0] + 4'd9};
    end else begin
      return 5'b0_0000;
    end
  endfunction

endpackage

// File: rtl/rom_ext_decode.sv
// Maps the last two characters of an expansion ROM file extension to a
// starting ROM page. Two hex digits give the page number; "ZZ" and "Z0"
// select page 0, and "Z0" additionally marks a two-part combo image.
module rom_ext_decode
  import amstrad_pkg::*;
(
  input  logic [15:0] ext,
  output logic [8:0]  page,
  output logic        combo
);

  logic [1:0] nib_valid;
  logic [3:0] nib_val [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_char
      logic [4:0] dec;
      assign dec           = hex_nibble(ext[gi*8 +: 8]);
      assign nib_valid[gi] = dec[4];
      assign nib_val[gi]   = dec[3:0];
    end
  endgenerate

  // Default page, then per-digit overrides, then the special "Z" names
  always_comb begin
    page  = PAGE_EXP_DEFAULT;
    combo = 1'b0;
    if (nib_valid[1]) page[7:4] = nib_val[1];
    if (nib_valid[0]) page[3:0] = nib_val[0];
    if (ext == 16'h5A5A) begin
      page = PAGE_OS;
    end
    if (ext == 16'h5A30) begin
      page  = PAGE_OS;
      combo = 1'b1;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Turns host download bytes into paced SDRAM write requests, one write per
// ce_ref window, and records which upper ROM pages have been loaded.
module rom_loader
  import amstrad_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic [31:0] ioctl_file_ext,
  output logic        ioctl_wait,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [1:0]  boot_bank,
  output logic [7:0]  boot_dout,
  input  logic [7:0]  map_addr,
  output logic        rom_present
);

  load_state_t state_reg, state_next;

  logic [8:0]   page_reg;
  logic         combo_reg;
  logic         download_reg;
  logic         dual_reg;
  // Loaded-page map: cleared only by configuration, survives board reset
  logic [255:0] rom_map = '0;

  logic [8:0]  dec_page;
  logic        dec_combo;
  logic        dl_rise;
  logic        discard;
  logic        dual;
  logic [8:0]  sys_page;
  logic [22:0] boot_a_next;
  logic [1:0]  boot_bank_next;

  logic accept, arm_fire, second_bank, commit;

  // Only the last two extension characters carry page information
  logic unused_ext;
  assign unused_ext = ^ioctl_file_ext[31:16];

  rom_ext_decode u_ext_decode (
    .ext   (ioctl_file_ext[15:0]),
    .page  (dec_page),
    .combo (dec_combo)
  );

  assign dl_rise = ioctl_download & ~download_reg;
  // System ROM set has only eight 16 KiB blocks; anything beyond is dropped
  assign discard = (ioctl_index == 8'h00) && (ioctl_addr[24:17] != 8'h00);
  assign dual    = (ioctl_index[7:6] == 2'b01) | (ioctl_index[5:0] != 6'h00);

  // Target address and bank for the byte currently offered by the host
  always_comb begin
    sys_page = PAGE_OS;
    case (ioctl_addr[15:14])
      2'd0: sys_page = PAGE_OS;
      2'd1: sys_page = PAGE_BASIC;
      2'd2: sys_page = PAGE_AMSDOS;
      default: sys_page = PAGE_HIGH;
    endcase
    if (ioctl_index != 8'h00) begin
      boot_a_next    = {page_reg[8], page_reg[7:0] + ioctl_addr[21:14], ioctl_addr[13:0]};
      boot_bank_next = {1'b0, &ioctl_index[7:6]};
    end else begin
      boot_a_next    = {sys_page, ioctl_addr[13:0]};
      boot_bank_next = {1'b0, ioctl_addr[16]};
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state and one-cycle action strobes
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    arm_fire    = 1'b0;
    second_bank = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ioctl_download && ioctl_wr && !discard) begin
          accept     = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        if (ce_ref) begin
          arm_fire   = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (ce_ref) begin
          if (dual_reg && boot_bank == 2'b00) begin
            second_bank = 1'b1;
            state_next  = ARM;
          end else begin
            commit     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and bank outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      boot_wr    <= 1'b0;
      boot_bank  <= 2'b00;
    end else begin
      if (accept) begin
        ioctl_wait <= 1'b1;
        boot_bank  <= boot_bank_next;
      end
      if (arm_fire) boot_wr <= 1'b1;
      if (second_bank) begin
        boot_wr   <= 1'b0;
        boot_bank <= 2'b01;
      end
      if (commit) begin
        boot_wr    <= 1'b0;
        ioctl_wait <= 1'b0;
      end
    end
  end

  // Address/data hold registers, frozen from acceptance until back in IDLE
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      boot_a    <= boot_a_next;
      boot_dout <= ioctl_dout;
      dual_reg  <= dual;
    end
  end

  // Page selection on download start; combo image switches page after its first 16 KiB
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      page_reg     <= 9'h000;
      combo_reg    <= 1'b0;
      download_reg <= 1'b0;
    end else begin
      download_reg <= ioctl_download;
      if (dl_rise && ioctl_index != 8'h00) begin
        page_reg  <= dec_page;
        combo_reg <= dec_combo;
      end else if (commit && combo_reg && boot_a[13:0] == 14'h3FFF) begin
        combo_reg <= 1'b0;
        page_reg  <= PAGE_HIGH;
      end
    end
  end

  // Mark upper ROM pages as present once a byte is committed to them
  always_ff @(posedge clk_sys) begin
    if (!reset && commit && boot_a[22]) begin
      rom_map[boot_a[21:14]] <= 1'b1;
    end
  end

  // Registered page-present lookup
  always_ff @(posedge clk_sys) begin
    if (reset) rom_present <= 1'b0;
    else       rom_present <= rom_map[map_addr];
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: drives host bytes, logs every SDRAM write
// strobe and compares against hand-computed addresses, banks and data.
`timescale 1ns/1ps
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_ref = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic [31:0] ioctl_file_ext = '0;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic [7:0]  map_addr = '0;
  logic        rom_present;

  logic [3:0]  ce_cnt = '0;
  logic        wr_prev = 1'b0;
  logic [22:0] log_a[$];
  logic [1:0]  log_bank[$];
  logic [7:0]  log_dout[$];

  int n_checks = 0;
  int n_fail = 0;

  rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_file_ext (ioctl_file_ext),
    .ioctl_wait     (ioctl_wait),
    .boot_wr        (boot_wr),
    .boot_a         (boot_a),
    .boot_bank      (boot_bank),
    .boot_dout      (boot_dout),
    .map_addr       (map_addr),
    .rom_present    (rom_present)
  );

  always #5 clk_sys = ~clk_sys;

  // One-in-sixteen SDRAM refresh strobe
  always @(posedge clk_sys) begin
    ce_cnt <= ce_cnt + 4'd1;
    ce_ref <= (ce_cnt == 4'd14);
  end

  // Log each write request at its rising strobe
  always @(negedge clk_sys) begin
    if (boot_wr && !wr_prev) begin
      log_a.push_back(boot_a);
      log_bank.push_back(boot_bank);
      log_dout.push_back(boot_dout);
      $display("%0t sdram write a=0x%06h bank=%0d data=0x%02h", $time, boot_a, boot_bank, boot_dout);
    end
    wr_prev <= boot_wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    tick();
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    $display("%0t host byte addr=0x%07h data=0x%02h", $time, addr, data);
  endtask

  task automatic wait_release(input string tag, output int cycles);
    cycles = 0;
    while (ioctl_wait === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    check(tag, {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
    ioctl_index    = idx;
    ioctl_file_ext = {16'h2E52, ext};
    tick();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic probe_map(input logic [7:0] page, input logic exp, input string tag);
    map_addr = page;
    tick();
    check(tag, {31'd0, rom_present}, {31'd0, exp});
  endtask

  initial begin
    int n0;
    int cyc;
    logic [24:0] z_addr [4];
    logic [22:0] z_exp  [4];
    z_addr = '{25'h0000000, 25'h0003FFF, 25'h0004000, 25'h0007FFF};
    // Combo page 0 for the first 16 KiB, then page 0x1FF plus offset block 1 wraps to 0x100
    z_exp  = '{23'h000000, 23'h003FFF, 23'h400000, 23'h403FFF};

    // Reset state
    tick(); tick();
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_boot_wr", {31'd0, boot_wr}, 32'd0);
    check("rst_bank", {30'd0, boot_bank}, 32'd0);
    check("rst_present", {31'd0, rom_present}, 32'd0);
    reset = 1'b0;
    tick();

    // System ROM set: block 1 -> page 0x100 bank 0, block 5 -> bank 1, block 8 dropped
    start_dl(8'h00, 16'h4F4D);
    n0 = log_a.size();
    send_byte(25'h0004005, 8'hA5);
    check("s1_wait_set", {31'd0, ioctl_wait}, 32'd1);
    wait_release("s1_release", cyc);
    check("s1_latency", {31'd0, (cyc >= 16 && cyc <= 32)}, 32'd1);
    check("s1_count", log_a.size(), n0 + 1);
    check("s1_addr", log_a[n0], 32'h400005);
    check("s1_bank", log_bank[n0], 32'd0);
    check("s1_data", log_dout[n0], 32'hA5);
    n0 = log_a.size();
    send_byte(25'h0014005, 8'h5A);
    wait_release("s1b_release", cyc);
    check("s1b_count", log_a.size(), n0 + 1);
    check("s1b_addr", log_a[n0], 32'h400005);
    check("s1b_bank", log_bank[n0], 32'd1);
    check("s1b_data", log_dout[n0], 32'h5A);
    n0 = log_a.size();
    send_byte(25'h0020000, 8'h11);
    check("blk8_no_wait", {31'd0, ioctl_wait}, 32'd0);
    repeat (40) tick();
    check("blk8_no_write", log_a.size(), n0);
    end_dl();

    // Expansion "07", dual-bank index 0x40
    probe_map(8'h07, 1'b0, "s2_map_before");
    start_dl(8'h40, 16'h3037);
    n0 = log_a.size();
    send_byte(25'h0000010, 8'h77);
    wait_release("s2_release", cyc);
    check("s2_latency", {31'd0, (cyc >= 48 && cyc <= 64)}, 32'd1);
    check("s2_count", log_a.size(), n0 + 2);
    check("s2_addr0", log_a[n0], 32'h41C010);
    check("s2_bank0", log_bank[n0], 32'd0);
    check("s2_addr1", log_a[n0+1], 32'h41C010);
    check("s2_bank1", log_bank[n0+1], 32'd1);
    end_dl();
    probe_map(8'h07, 1'b1, "s2_map_after");

    // Expansion "XY", index 0xC0: default page 0x1EE, single write in bank 1
    probe_map(8'hEE, 1'b0, "s3_map_before");
    start_dl(8'hC0, 16'h5859);
    n0 = log_a.size();
    send_byte(25'h0000000, 8'h3C);
    wait_release("s3_release", cyc);
    check("s3_count", log_a.size(), n0 + 1);
    check("s3_addr", log_a[n0], 32'h7B8000);
    check("s3_bank", log_bank[n0], 32'd1);
    end_dl();
    probe_map(8'hEE, 1'b1, "s3_map_after");

    // Combo "Z0" image: sparse bytes across the 16 KiB boundary
    start_dl(8'hC0, 16'h5A30);
    for (int i = 0; i < 4; i++) begin
      n0 = log_a.size();
      send_byte(z_addr[i], 8'h80 + 8'(i));
      wait_release("z0_release", cyc);
      check("z0_count", log_a.size(), n0 + 1);
      check("z0_addr", log_a[n0], {9'd0, z_exp[i]});
    end
    end_dl();

    // Reset during WRITE aborts without commit; map survives
    probe_map(8'h3A, 1'b0, "s5_map_before");
    map_addr = 8'hEE;
    start_dl(8'hC0, 16'h3341);
    send_byte(25'h0000001, 8'h99);
    cyc = 0;
    while (boot_wr !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("s5_in_write", {31'd0, boot_wr}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_rst_wr", {31'd0, boot_wr}, 32'd0);
    check("s5_rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("s5_rst_present", {31'd0, rom_present}, 32'd0);
    probe_map(8'hEE, 1'b1, "s5_map_kept");
    probe_map(8'h3A, 1'b0, "s5_no_commit");
    end_dl();
    start_dl(8'hC0, 16'h3341);
    n0 = log_a.size();
    send_byte(25'h0000001, 8'h99);
    wait_release("s5_release", cyc);
    check("s5_count", log_a.size(), n0 + 1);
    check("s5_addr", log_a[n0], 32'h4E8001);
    check("s5_bank", log_bank[n0], 32'd1);
    end_dl();
    probe_map(8'h3A, 1'b1, "s5_map_after");

    // Second strobe while busy is ignored
    start_dl(8'hC0, 16'h5859);
    n0 = log_a.size();
    send_byte(25'h0000100, 8'hAB);
    ioctl_addr = 25'h0000200;
    ioctl_dout = 8'hCD;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    wait_release("s6_release", cyc);
    repeat (40) tick();
    check("s6_count", log_a.size(), n0 + 1);
    check("s6_addr", log_a[n0], 32'h7B8100);
    check("s6_data", log_dout[n0], 32'hAB);
    end_dl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
